// File: rtl/paicore_send_xc_mc.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// paicore_send_xc_mc
// Multi-channel PAICORE sender. Accepts AXIS beats of DATA_WIDTH bits, counts
// them against a programmed length and splits each beat into 32-bit words.
// Words are steered round-robin (one whole beat per masked channel) or
// broadcast to every masked channel. Each channel owns a word FIFO feeding a
// 4-phase request/acknowledge link. Completion is reported once every masked
// link has drained.
//
// Ports:
//   s_axis_aclk / s_axis_aresetn : clock, asynchronous active-low reset
//   start, mode, chan_mask,
//   send_len                     : transfer setup, latched on start in IDLE
//   s_axis_t*                    : AXI-Stream input
//   acknowledge / request / dout : per-channel handshake links (32b each)
//   busy                         : RUN, DRAIN or DONE
//   o_tx_done                    : one-cycle completion pulse
//   o_early_last                 : sticky, tlast arrived before send_len beats
// -----------------------------------------------------------------------------
module paicore_send_xc_mc #(
   parameter int Channel    = 4,
   parameter int DATA_WIDTH = 64,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                    s_axis_aclk,
   input  logic                    s_axis_aresetn,
   input  logic                    start,
   input  logic                    mode,
   input  logic [Channel-1:0]      chan_mask,
   input  logic [31:0]             send_len,
   output logic                    s_axis_tready,
   input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic                    s_axis_tlast,
   input  logic                    s_axis_tvalid,
   input  logic [Channel-1:0]      acknowledge,
   output logic [Channel*32-1:0]   dout,
   output logic [Channel-1:0]      request,
   output logic                    busy,
   output logic                    o_tx_done,
   output logic                    o_early_last
);

   localparam int WORDS = DATA_WIDTH / 32;
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int CW    = AW + 1;
   localparam int PW    = (Channel > 1) ? $clog2(Channel) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
   typedef enum logic [1:0] {L_IDLE, L_REQ, L_ACKLO}         lstate_t;

   state_t                r_state, w_nstate;
   logic [31:0]           r_len, r_beat_cnt;
   logic                  r_mode, r_early_last, r_tx_done;
   logic [Channel-1:0]    r_mask;
   logic [PW-1:0]         r_ptr;

   logic [31:0]           r_mem  [Channel][2**AW];
   logic [AW-1:0]         r_wptr [Channel];
   logic [AW-1:0]         r_rptr [Channel];
   logic [CW-1:0]         r_cnt  [Channel];
   lstate_t               r_lst  [Channel];
   lstate_t               w_lnext[Channel];
   logic [Channel*32-1:0] r_dout;
   logic [Channel-1:0]    r_req;

   logic [PW-1:0]         w_tgt, w_nptr;
   logic                  w_tgt_ok, w_nxt_ok, w_ready, w_acc, w_early, w_all_idle;
   logic [Channel-1:0]    w_room, w_we, w_pop, w_load;
   logic [32:0]           w_cnt_inc;
   int                    w_idx;

   // Round-robin target: first masked channel at or after the pointer, and the
   // masked channel following that target for the pointer update.
   always_comb begin
      w_tgt    = '0;
      w_tgt_ok = 1'b0;
      w_nptr   = r_ptr;
      w_nxt_ok = 1'b0;
      w_idx    = 0;
      for (int k = 0; k < Channel; k++) begin
         w_idx = int'(r_ptr) + k;
         if (w_idx >= Channel) w_idx = w_idx - Channel;
         if (!w_tgt_ok && r_mask[w_idx[PW-1:0]]) begin
            w_tgt    = w_idx[PW-1:0];
            w_tgt_ok = 1'b1;
         end
      end
      for (int k = 1; k <= Channel; k++) begin
         w_idx = int'(w_tgt) + k;
         if (w_idx >= Channel) w_idx = w_idx - Channel;
         if (!w_nxt_ok && r_mask[w_idx[PW-1:0]]) begin
            w_nptr   = w_idx[PW-1:0];
            w_nxt_ok = 1'b1;
         end
      end
   end

   // FIFO room, write enables and link next-state
   always_comb begin
      w_room     = '0;
      w_we       = '0;
      w_pop      = '0;
      w_load     = '0;
      w_all_idle = 1'b1;
      for (int c = 0; c < Channel; c++) begin
         w_room[c] = (r_cnt[c] <= CW'(FIFO_DEPTH - WORDS));
      end
      w_ready = (r_state == S_RUN) &&
                (r_mode ? (&(w_room | ~r_mask)) : (w_tgt_ok && w_room[w_tgt]));
      w_acc   = w_ready && s_axis_tvalid;
      for (int c = 0; c < Channel; c++) begin
         w_we[c]    = w_acc && (r_mode ? r_mask[c] : (w_tgt == PW'(c)));
         w_lnext[c] = r_lst[c];
         case (r_lst[c])
            L_IDLE:  if (r_cnt[c] != '0) begin
                        w_lnext[c] = L_REQ;
                        w_load[c]  = 1'b1;
                     end
            L_REQ:   if (acknowledge[c]) begin
                        w_lnext[c] = L_ACKLO;
                        w_pop[c]   = 1'b1;
                     end
            L_ACKLO: if (!acknowledge[c]) w_lnext[c] = L_IDLE;
            default: w_lnext[c] = L_IDLE;
         endcase
         if (r_mask[c] && ((r_cnt[c] != '0) || (r_lst[c] != L_IDLE))) w_all_idle = 1'b0;
      end
   end

   // 33-bit increment keeps send_len=32'hFFFFFFFF from wrapping before compare.
   assign w_cnt_inc = {1'b0, r_beat_cnt} + 33'd1;
   assign w_early   = w_acc && s_axis_tlast && (w_cnt_inc < {1'b0, r_len});

   // Top FSM next state
   always_comb begin
      w_nstate = r_state;
      case (r_state)
         S_IDLE:  if (start) w_nstate = ((send_len == 32'd0) || (chan_mask == '0)) ? S_DONE : S_RUN;
         S_RUN:   if (w_acc && ((w_cnt_inc == {1'b0, r_len}) || w_early)) w_nstate = S_DRAIN;
         S_DRAIN: if (w_all_idle) w_nstate = S_DONE;
         S_DONE:  w_nstate = S_IDLE;
         default: w_nstate = S_IDLE;
      endcase
   end

   always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
      if (!s_axis_aresetn) begin
         r_state      <= S_IDLE;
         r_len        <= '0;
         r_beat_cnt   <= '0;
         r_mode       <= 1'b0;
         r_mask       <= '0;
         r_ptr        <= '0;
         r_early_last <= 1'b0;
         r_tx_done    <= 1'b0;
      end else begin
         r_state   <= w_nstate;
         r_tx_done <= (r_state == S_DONE);
         if ((r_state == S_IDLE) && start) begin
            r_len        <= send_len;
            r_mode       <= mode;
            r_mask       <= chan_mask;
            r_beat_cnt   <= '0;
            r_ptr        <= '0;
            r_early_last <= 1'b0;
         end
         if (w_acc) begin
            r_beat_cnt <= w_cnt_inc[31:0];
            if (!r_mode) r_ptr <= w_nptr;
         end
         if (w_early) r_early_last <= 1'b1;
      end
   end

   // FIFO storage carries no reset; emptiness is tracked by the counters.
   always_ff @(posedge s_axis_aclk) begin
      for (int c = 0; c < Channel; c++) begin
         for (int w = 0; w < WORDS; w++) begin
            if (w_we[c]) r_mem[c][r_wptr[c] + AW'(w)] <= s_axis_tdata[32*w +: 32];
         end
      end
   end

   always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
      if (!s_axis_aresetn) begin
         for (int c = 0; c < Channel; c++) begin
            r_wptr[c] <= '0;
            r_rptr[c] <= '0;
            r_cnt[c]  <= '0;
            r_lst[c]  <= L_IDLE;
         end
         r_dout <= '0;
         r_req  <= '0;
      end else begin
         for (int c = 0; c < Channel; c++) begin
            if (w_we[c])  r_wptr[c] <= r_wptr[c] + AW'(WORDS);
            if (w_pop[c]) r_rptr[c] <= r_rptr[c] + AW'(1);
            r_cnt[c] <= r_cnt[c] + (w_we[c] ? CW'(WORDS) : CW'(0)) - (w_pop[c] ? CW'(1) : CW'(0));
            r_lst[c] <= w_lnext[c];
            // dout is only loaded when a new word is presented, so it holds
            // its last value after request falls.
            if (w_load[c]) begin
               r_dout[32*c +: 32] <= r_mem[c][r_rptr[c]];
               r_req[c]           <= 1'b1;
            end
            if (w_pop[c]) r_req[c] <= 1'b0;
         end
      end
   end

   assign s_axis_tready = w_ready;
   assign dout          = r_dout;
   assign request       = r_req;
   assign busy          = (r_state != S_IDLE);
   assign o_tx_done     = r_tx_done;
   assign o_early_last  = r_early_last;

endmodule
